// File: rtl/wash_pkg.sv
`default_nettype none
//============================================================================
// Module : wash_pkg
// Brief  : Phase codes and enable-vector layout shared by the wash sequencer
//          and the display driver.
// Rev    : 1.0  initial release
//============================================================================
package wash_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      DRAIN = 3'd3,
      RINSE = 3'd4,
      SPIN  = 3'd5,
      DONE  = 3'd6
   } phase_t;

   localparam int EN_W         = 4;
   localparam int EN_WATER_IN  = 0;
   localparam int EN_WATER_OUT = 1;
   localparam int EN_MOTOR     = 2;
   localparam int EN_SPIN      = 3;

   function automatic logic [EN_W-1:0] phase_enables(input phase_t ph);
      logic [EN_W-1:0] en;
      en = '0;
      case (ph)
         FILL:        en[EN_WATER_IN] = 1'b1;
         WASH, RINSE: en[EN_MOTOR]    = 1'b1;
         DRAIN:       en[EN_WATER_OUT] = 1'b1;
         SPIN: begin
            en[EN_SPIN]      = 1'b1;
            en[EN_WATER_OUT] = 1'b1;
         end
         default:     en = '0;
      endcase
      return en;
   endfunction

   function automatic logic is_active(input phase_t ph);
      return (ph == FILL) || (ph == WASH) || (ph == DRAIN) ||
             (ph == RINSE) || (ph == SPIN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wash_sequencer_if.sv
`default_nettype none
//============================================================================
// Module : wash_sequencer_if
// Brief  : Button/tick inputs and actuator/display outputs of the sequencer.
// Rev    : 1.0  initial release
//============================================================================
interface wash_sequencer_if #(
   parameter int TW = 8
);
   logic          resetBtn;
   logic          runBtn;
   logic          WaterBtn;
   logic          openBtn;
   logic          click;
   logic          water_in;
   logic          water_out;
   logic          motor;
   logic          spin;
   logic          paused;
   logic          done;
   logic [2:0]    phase;
   logic [1:0]    level;
   logic [TW-1:0] remain;

   modport master (
      output resetBtn, runBtn, WaterBtn, openBtn, click,
      input  water_in, water_out, motor, spin, paused, done, phase, level, remain
   );

   modport slave (
      input  resetBtn, runBtn, WaterBtn, openBtn, click,
      output water_in, water_out, motor, spin, paused, done, phase, level, remain
   );
endinterface
`default_nettype wire

// File: rtl/wash_sequencer_phase_timer.sv
`default_nettype none
//============================================================================
// Module : phase_timer
// Brief  : Loadable down-counter timing one wash phase; flags the final tick.
// Rev    : 1.0  initial release
//============================================================================
module phase_timer #(
   parameter int TW = 8
) (
   input  wire logic          cp,
   input  wire logic          rst_n,
   input  wire logic          load,
   input  wire logic [TW-1:0] load_val,
   input  wire logic          en,
   input  wire logic          tick,
   output logic      [TW-1:0] remain,
   output logic               expire
);

   logic [TW-1:0] remain_q;
   logic [TW-1:0] remain_d;

   // Load wins over counting; a zero count never wraps.
   always_comb begin
      remain_d = remain_q;
      if (load) begin
         remain_d = load_val;
      end else if (en && tick && (remain_q != '0)) begin
         remain_d = remain_q - {{(TW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
         remain_q <= '0;
      end else begin
         remain_q <= remain_d;
      end
   end

   assign remain = remain_q;
   assign expire = en & tick & (remain_q == {{(TW-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/wash_sequencer.sv
`default_nettype none
//============================================================================
// Module : wash_sequencer
// Brief  : Washing-cycle FSM sequencing FILL/WASH/DRAIN/RINSE/SPIN phases.
// Rev    : 1.0  initial release
//============================================================================
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int FILL_T    = 4,
   parameter int WASH_T    = 20,
   parameter int DRAIN_T   = 5,
   parameter int RINSE_T   = 10,
   parameter int SPIN_T    = 8,
   parameter int RINSE_CNT = 2,
   parameter int TW        = 8
) (
   input  wire logic       cp,
   input  wire logic       rst_n,
   wash_sequencer_if.slave bus
);

   localparam logic [TW-1:0] c_fill_unit = TW'(FILL_T);
   localparam logic [TW-1:0] c_wash_len  = TW'(WASH_T);
   localparam logic [TW-1:0] c_drain_len = TW'(DRAIN_T);
   localparam logic [TW-1:0] c_rinse_len = TW'(RINSE_T);
   localparam logic [TW-1:0] c_spin_len  = TW'(SPIN_T);
   localparam logic [1:0]    c_rinse_cnt = 2'(RINSE_CNT);

   phase_t          phase_q, phase_d;
   logic [1:0]      level_q, level_d;
   logic [1:0]      rinse_q, rinse_d;
   logic            pause_q, pause_d;
   logic            run_q, run_d;
   logic            water_q, water_d;
   logic [EN_W-1:0] en_q, en_d;
   logic            paused_q, paused_d;
   logic            done_q, done_d;

   logic            w_rise_run;
   logic            w_rise_water;
   logic            w_t_load;
   logic [TW-1:0]   w_t_load_val;
   logic            w_t_en;
   logic [TW-1:0]   w_remain;
   logic            w_expire;
   logic [TW-1:0]   w_fill_len;

   assign w_rise_run   = bus.runBtn & ~run_q;
   assign w_rise_water = bus.WaterBtn & ~water_q;
   assign w_fill_len   = c_fill_unit * TW'(level_q);

   // The timer only counts when no higher-priority event claims this cycle.
   assign w_t_en = is_active(phase_q) & ~bus.resetBtn & ~bus.openBtn &
                   ~w_rise_run & ~pause_q;

   phase_timer #(
      .TW (TW)
   ) u_phase_timer (
      .cp       (cp),
      .rst_n    (rst_n),
      .load     (w_t_load),
      .load_val (w_t_load_val),
      .en       (w_t_en),
      .tick     (bus.click),
      .remain   (w_remain),
      .expire   (w_expire)
   );

   always_comb begin
      phase_d      = phase_q;
      level_d      = level_q;
      rinse_d      = rinse_q;
      pause_d      = pause_q;
      run_d        = bus.runBtn;
      water_d      = bus.WaterBtn;
      w_t_load     = 1'b0;
      w_t_load_val = '0;

      if (bus.resetBtn) begin
         phase_d  = IDLE;
         pause_d  = 1'b0;
         rinse_d  = '0;
         w_t_load = 1'b1;
      end else begin
         case (phase_q)
            IDLE: begin
               if (w_rise_run) begin
                  phase_d      = FILL;
                  rinse_d      = '0;
                  pause_d      = 1'b0;
                  w_t_load     = 1'b1;
                  w_t_load_val = w_fill_len;
               end else if (w_rise_water) begin
                  level_d = (level_q == 2'd3) ? 2'd1 : level_q + 2'd1;
               end
            end
            DONE: begin
               if (w_rise_run) begin
                  phase_d  = IDLE;
                  w_t_load = 1'b1;
               end
            end
            default: begin
               if (!bus.openBtn && w_rise_run) begin
                  pause_d = ~pause_q;
               end else if (w_expire) begin
                  w_t_load = 1'b1;
                  case (phase_q)
                     FILL: begin
                        // A non-zero rinse count means this fill feeds a rinse.
                        if (rinse_q == 2'd0) begin
                           phase_d      = WASH;
                           w_t_load_val = c_wash_len;
                        end else begin
                           phase_d      = RINSE;
                           w_t_load_val = c_rinse_len;
                        end
                     end
                     WASH, RINSE: begin
                        phase_d      = DRAIN;
                        w_t_load_val = c_drain_len;
                     end
                     DRAIN: begin
                        if (rinse_q < c_rinse_cnt) begin
                           phase_d      = FILL;
                           rinse_d      = rinse_q + 2'd1;
                           w_t_load_val = w_fill_len;
                        end else begin
                           phase_d      = SPIN;
                           w_t_load_val = c_spin_len;
                        end
                     end
                     default: begin
                        phase_d = DONE;
                        pause_d = 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end

      paused_d = is_active(phase_d) & (pause_d | bus.openBtn);
      done_d   = (phase_d == DONE);
      en_d     = paused_d ? '0 : phase_enables(phase_d);
   end

   always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= IDLE;
         level_q  <= 2'd1;
         rinse_q  <= '0;
         pause_q  <= 1'b0;
         run_q    <= 1'b0;
         water_q  <= 1'b0;
         en_q     <= '0;
         paused_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         level_q  <= level_d;
         rinse_q  <= rinse_d;
         pause_q  <= pause_d;
         run_q    <= run_d;
         water_q  <= water_d;
         en_q     <= en_d;
         paused_q <= paused_d;
         done_q   <= done_d;
      end
   end

   assign bus.water_in  = en_q[EN_WATER_IN];
   assign bus.water_out = en_q[EN_WATER_OUT];
   assign bus.motor     = en_q[EN_MOTOR];
   assign bus.spin      = en_q[EN_SPIN];
   assign bus.paused    = paused_q;
   assign bus.done      = done_q;
   assign bus.phase     = phase_q;
   assign bus.level     = level_q;
   assign bus.remain    = w_remain;

endmodule
`default_nettype wire
